melody_sequencer: RTL and testbench
===================================

# melody_sequencer

Plays the 64-step melody stored in the notes ROM. It drives the ROM's note index at a fixed tempo and takes back the returned half-period divider. From that divider it produces a square-wave audio output with an articulation gap between steps. It sits between the control inputs and the speaker pin, wrapping the combinational ROM.

## Interface
- `BW`, 16: width of the divider value from the ROM.
- `NOTE_TICKS`, 1500000: clock cycles per melody step (125 ms at 12 MHz). Must be greater than `GAP_TICKS`.
- `GAP_TICKS`, 120000: silent cycles at the end of each step. Must be ≥ 1.
- One clock; reset is asynchronous and active-high.
- `clk_i`  in  1  system clock (12 MHz nominal).
- `rst_i`  in  1  asynchronous active-high reset.
- `start_i`  in  1  start playback from step 0. Ignored while busy.
- `stop_i`  in  1  abort playback. Has priority over `start_i`.
- `loop_i`  in  1  sampled at the last step; 1 = restart at step 0 instead of finishing.
- `note_index_o`  out  6  ROM address, registered.
- `divider_value_i`  in  BW  half-period in clock cycles from the ROM; 0 = rest.
- `audio_o`  out  1  square-wave output, registered.
- `busy_o`  out  1  high in TONE and GAP.
- `done_o`  out  1  one-cycle pulse on normal completion.

## Operation
- FSM states: IDLE, TONE, GAP. Registers: `state`, `note_index_o`, tick counter (`$clog2(NOTE_TICKS)` bits), half-period counter (BW bits), `audio_o`, `done_o`.
- IDLE:
  - `audio_o`=0, `note_index_o`=0, counters cleared.
  - `start_i`=1 and `stop_i`=0 → TONE.
- TONE:
  - Tick counter increments each cycle.
  - When `divider_value_i`=D≠0: the half-period counter counts 0..D-1. On reaching D-1 it wraps to 0 and `audio_o` toggles. The output frequency is f_clk/(2D).
  - When D=0: `audio_o` is held 0 and the half-period counter is held 0.
  - At tick `NOTE_TICKS-GAP_TICKS-1` → GAP.
- GAP:
  - `audio_o` is forced 0 and the half-period counter is cleared.
  - At tick `NOTE_TICKS-1` the tick counter goes to 0 and the step ends.
- End of step:
  - If index < 63: index+1, → TONE.
  - If index = 63 and `loop_i`=1: index 0, → TONE.
  - If index = 63 and `loop_i`=0: → IDLE and `done_o`=1 for one cycle.
- Every TONE entry starts with `audio_o`=0 and the half-period counter at 0. The index is stable for a whole step, so the divider from the combinational ROM is valid in the first TONE cycle.
- `stop_i`=1 in any state → IDLE on the next edge with `audio_o`=0 and index 0; no `done_o` pulse.
- Index wrap 63→0 occurs only through the loop path.

## Timing
- Reset values:
  - `state`=IDLE.
  - `note_index_o`=0.
  - `audio_o`=0.
  - `busy_o`=0.
  - `done_o`=0.
  - all counters 0.
- `start_i` sampled at edge N → `busy_o`=1 and TONE with index 0 from edge N.
- With D≠0 constant, the first rising edge of `audio_o` appears D cycles after TONE entry. Subsequent toggles come every D cycles.
- Each step lasts exactly `NOTE_TICKS` cycles: `NOTE_TICKS-GAP_TICKS` in TONE, then `GAP_TICKS` in GAP.
- `note_index_o` changes on the same edge that enters TONE.
- One pass takes 64·`NOTE_TICKS` cycles from start until `done_o` is asserted.
- `done_o` is high in the first IDLE cycle only. `busy_o` is low in that same cycle.
- `busy_o` is decoded from `state` and carries no additional latency.
- Reset asserted mid-note: all outputs return to reset values immediately (asynchronous).

## Configuration
- `MELODY_GAP_EN`:
  - Defined: the GAP state is built and behaves as above.
  - Undefined: the GAP state is not built and `GAP_TICKS` is ignored. TONE lasts the full `NOTE_TICKS` and the step ends at tick `NOTE_TICKS-1`. The half-period counter and `audio_o` are reset at each step boundary, so repeated equal notes are not separated by silence.

## Test plan
Bench setup: `NOTE_TICKS`=16, `GAP_TICKS`=4, `MELODY_GAP_EN` defined, stub ROM returning divider = index+1 (index 5 returns 0).
- Reset check: after reset, outputs are 0. Pulse `start_i` → `busy_o`=1 and index 0 next cycle.
- Index 0 (D=1): `audio_o` toggles every cycle for 12 cycles, then is 0 for 4 cycles. Index steps to 1 at cycle 16.
- Index 2 (D=3): `audio_o` goes 0,0,0,1,1,1,0,… within TONE. Index 5 (rest): `audio_o` stays 0 for all 16 cycles.
- Full pass with `loop_i`=0: `done_o` pulses once, 1024 cycles after start, and then `busy_o`=0. With `loop_i`=1: index goes 63→0 with no `done_o`.
- `stop_i` at step 10 tick 7: next cycle is IDLE with index 0 and `audio_o`=0, no `done_o`. A simultaneous `start_i`+`stop_i` leaves the block in IDLE.
- Assert `rst_i` mid-TONE: outputs clear asynchronously. Rebuild without `MELODY_GAP_EN`: index 0 toggles for all 16 cycles.

Source files
------------

// File: rtl/melody_sequencer.sv
// Step sequencer for the 64-entry notes ROM: drives the note index at a fixed tempo and
// turns the returned half-period divider into a square wave. Optional macro: MELODY_GAP_EN.
module melody_sequencer #(
  parameter int BW         = 16,
  parameter int NOTE_TICKS = 1500000,
  parameter int GAP_TICKS  = 120000
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic          loop_i,
  output logic [5:0]    note_index_o,
  input  logic [BW-1:0] divider_value_i,
  output logic          audio_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam int TW = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;

  // Without the gap, TONE runs to the last tick of the step and GAP_TICKS has no effect.
`ifdef MELODY_GAP_EN
  localparam int GAP_LEN = GAP_TICKS;
`else
  localparam int GAP_LEN = GAP_TICKS * 0;
`endif

  localparam logic [TW-1:0] TONE_LAST = TW'(NOTE_TICKS - GAP_LEN - 1);
`ifdef MELODY_GAP_EN
  localparam logic [TW-1:0] STEP_LAST = TW'(NOTE_TICKS - 1);
`endif

  typedef enum logic [1:0] {
    IDLE,
    TONE
`ifdef MELODY_GAP_EN
    , GAP
`endif
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] tick, tick_n;
  logic [BW-1:0] hp, hp_n;
  logic [5:0]    idx_n;
  logic          audio_n;
  logic          done_n;
  logic          step_end;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      tick         <= '0;
      hp           <= '0;
      note_index_o <= '0;
      audio_o      <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      state        <= state_n;
      tick         <= tick_n;
      hp           <= hp_n;
      note_index_o <= idx_n;
      audio_o      <= audio_n;
      done_o       <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    tick_n   = tick;
    hp_n     = hp;
    idx_n    = note_index_o;
    audio_n  = audio_o;
    done_n   = 1'b0;
    step_end = 1'b0;

    if (stop_i) begin
      state_n = IDLE;
      tick_n  = '0;
      hp_n    = '0;
      idx_n   = '0;
      audio_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tick_n  = '0;
          hp_n    = '0;
          idx_n   = '0;
          audio_n = 1'b0;
          if (start_i) state_n = TONE;
        end
        TONE: begin
          tick_n = tick + TW'(1);
          if (divider_value_i == '0) begin
            hp_n    = '0;
            audio_n = 1'b0;
          end else if (hp == divider_value_i - BW'(1)) begin
            hp_n    = '0;
            audio_n = ~audio_o;
          end else begin
            hp_n = hp + BW'(1);
          end
          // Leaving TONE always silences the output so the next TONE entry starts clean.
          if (tick == TONE_LAST) begin
            hp_n    = '0;
            audio_n = 1'b0;
`ifdef MELODY_GAP_EN
            state_n = GAP;
`else
            step_end = 1'b1;
`endif
          end
        end
`ifdef MELODY_GAP_EN
        GAP: begin
          tick_n  = tick + TW'(1);
          hp_n    = '0;
          audio_n = 1'b0;
          if (tick == STEP_LAST) step_end = 1'b1;
        end
`endif
        default: begin
          state_n = IDLE;
        end
      endcase

      if (step_end) begin
        tick_n = '0;
        if (note_index_o != '1) begin
          idx_n   = note_index_o + 6'd1;
          state_n = TONE;
        end else if (loop_i) begin
          idx_n   = '0;
          state_n = TONE;
        end else begin
          idx_n   = '0;
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed self-checking bench for melody_sequencer with a stub ROM (divider = index+1, index 5 rests).
module tb_melody_sequencer;

  localparam int NT = 16;
  localparam int GT = 4;
  localparam int BW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop = 1'b0;
  logic [5:0]    note_index;
  logic [BW-1:0] divider;
  logic          audio;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  melody_sequencer #(
    .BW(BW),
    .NOTE_TICKS(NT),
    .GAP_TICKS(GT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .start_i(start),
    .stop_i(stop),
    .loop_i(loop),
    .note_index_o(note_index),
    .divider_value_i(divider),
    .audio_o(audio),
    .busy_o(busy),
    .done_o(done)
  );

  assign divider = (note_index == 6'd5) ? '0 : (BW'(note_index) + BW'(1));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected audio in cycle k (0 = first cycle after the step's entry edge).
  function automatic logic exp_audio(input int step, input int k);
    int d;
    d = (step == 5) ? 0 : step + 1;
`ifdef MELODY_GAP_EN
    if (k >= NT - GT) return 1'b0;
`endif
    if (d == 0) return 1'b0;
    return ((k / d) % 2) == 1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    total++; if (audio !== 1'b0) begin bad++; $display("FAIL reset_audio: got %0b expected 0", audio); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b expected 0", done); end
    total++; if (note_index !== 6'd0) begin bad++; $display("FAIL reset_index: got %0d expected 0", note_index); end
    rst = 1'b0;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_single_pass();
    loop  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 64 * NT; c++) begin
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL pass_busy c=%0d: got %0b expected 1", c, busy); end
      total++; if (note_index !== 6'(c / NT)) begin bad++; $display("FAIL pass_index c=%0d: got %0d expected %0d", c, note_index, c / NT); end
      total++; if (audio !== exp_audio(c / NT, c % NT)) begin bad++; $display("FAIL pass_audio c=%0d: got %0b expected %0b", c, audio, exp_audio(c / NT, c % NT)); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL pass_done_early c=%0d: got %0b expected 0", c, done); end
      tick();
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL pass_done: got %0b expected 1", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL pass_end_busy: got %0b expected 0", busy); end
    total++; if (note_index !== 6'd0) begin bad++; $display("FAIL pass_end_index: got %0d expected 0", note_index); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL pass_done_width: got %0b expected 0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL pass_idle_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_loop();
    loop  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 66 * NT; c++) begin
      // start while busy must be ignored
      start = (c == 300);
      total++; if (note_index !== 6'((c / NT) % 64)) begin bad++; $display("FAIL loop_index c=%0d: got %0d expected %0d", c, note_index, (c / NT) % 64); end
      total++; if (audio !== exp_audio((c / NT) % 64, c % NT)) begin bad++; $display("FAIL loop_audio c=%0d: got %0b expected %0b", c, audio, exp_audio((c / NT) % 64, c % NT)); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL loop_done c=%0d: got %0b expected 0", c, done); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL loop_busy c=%0d: got %0b expected 1", c, busy); end
      tick();
    end
    start = 1'b0;
    loop  = 1'b0;
    stop  = 1'b1;
    tick();
    stop  = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL loop_stop_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_stop();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 10 * NT + 7; c++) tick();
    total++; if (note_index !== 6'd10) begin bad++; $display("FAIL stop_pre_index: got %0d expected 10", note_index); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL stop_pre_busy: got %0b expected 1", busy); end
    total++; if (audio !== exp_audio(10, 7)) begin bad++; $display("FAIL stop_pre_audio: got %0b expected %0b", audio, exp_audio(10, 7)); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stop_busy: got %0b expected 0", busy); end
    total++; if (note_index !== 6'd0) begin bad++; $display("FAIL stop_index: got %0d expected 0", note_index); end
    total++; if (audio !== 1'b0) begin bad++; $display("FAIL stop_audio: got %0b expected 0", audio); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL stop_done: got %0b expected 0", done); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL stop_done_late: got %0b expected 0", done); end
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL start_stop_busy: got %0b expected 0", busy); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL start_stop_busy_late: got %0b expected 0", busy); end
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 2 * NT + 4; c++) tick();
    total++; if (note_index !== 6'd2) begin bad++; $display("FAIL areset_pre_index: got %0d expected 2", note_index); end
    total++; if (audio !== 1'b1) begin bad++; $display("FAIL areset_pre_audio: got %0b expected 1", audio); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (note_index !== 6'd0) begin bad++; $display("FAIL areset_index: got %0d expected 0", note_index); end
    total++; if (audio !== 1'b0) begin bad++; $display("FAIL areset_audio: got %0b expected 0", audio); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL areset_busy: got %0b expected 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL areset_done: got %0b expected 0", done); end
    tick();
    rst = 1'b0;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL areset_idle: got %0b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_loop();
    test_stop();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
